instr_issue: RTL and testbench

INSTR_ISSUE -- requirements
Module: instr_issue

---
 rtl/risc_pkg.sv | 50 +++++
 rtl/issue_scoreboard.sv | 28 ++
 rtl/instr_issue.sv | 145 ++++++++++++++
 tb/tb_instr_issue.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/risc_pkg.sv
// Shared ISA definitions: field positions, opcodes, decoded-op encoding, issue FSM states.
package risc_pkg;

    localparam int unsigned XLEN     = 32;
    localparam int unsigned NREGS    = 32;
    localparam int unsigned REG_AW   = 5;
    localparam int unsigned OPC_W    = 6;
    localparam int unsigned FUNCT_W  = 6;
    localparam int unsigned IMM_W    = 16;
    localparam int unsigned EX_OP_W  = 3;

    localparam int unsigned OPC_HI   = 31;
    localparam int unsigned OPC_LO   = 26;
    localparam int unsigned RS_HI    = 25;
    localparam int unsigned RS_LO    = 21;
    localparam int unsigned RT_HI    = 20;
    localparam int unsigned RT_LO    = 16;
    localparam int unsigned RD_HI    = 15;
    localparam int unsigned RD_LO    = 11;
    localparam int unsigned IMM_HI   = 15;
    localparam int unsigned IMM_LO   = 0;
    localparam int unsigned FUNCT_HI = 5;
    localparam int unsigned FUNCT_LO = 0;

    localparam logic [OPC_W-1:0] OPC_RTYPE = 6'h00;
    localparam logic [OPC_W-1:0] OPC_ADDI  = 6'h08;
    localparam logic [OPC_W-1:0] OPC_LW    = 6'h23;
    localparam logic [OPC_W-1:0] OPC_SW    = 6'h2B;
    localparam logic [OPC_W-1:0] OPC_BEQ   = 6'h04;

    typedef enum logic [EX_OP_W-1:0] {
        OP_RTYPE   = 3'd0,
        OP_ADDI    = 3'd1,
        OP_LW      = 3'd2,
        OP_SW      = 3'd3,
        OP_BEQ     = 3'd4,
        OP_ILLEGAL = 3'd5
    } ex_op_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ISSUED = 2'd1,
        ST_STALL  = 2'd2
    } issue_state_e;

    function automatic logic [XLEN-1:0] sext_imm(input logic [IMM_W-1:0] v);
        return {{(XLEN-IMM_W){v[IMM_W-1]}}, v};
    endfunction

endpackage

// File: rtl/issue_scoreboard.sv
// Register busy scoreboard: one bit per architectural register.
module issue_scoreboard
    import risc_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              i_set_en,
    input  logic [REG_AW-1:0] i_set_addr,
    input  logic              i_clr_en,
    input  logic [REG_AW-1:0] i_clr_addr,
    output logic [NREGS-1:0]  o_busy
);

    logic [NREGS-1:0] r_busy;

    // Clear on writeback, set on issue; the later set wins on a same-register collision.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_busy <= '0;
        end else begin
            if (i_clr_en) r_busy[i_clr_addr] <= 1'b0;
            if (i_set_en) r_busy[i_set_addr] <= 1'b1;
        end
    end

    assign o_busy = r_busy;

endmodule

// File: rtl/instr_issue.sv
// In-order single-slot issue stage: decode, hazard check against the busy scoreboard, hold for execute.
module instr_issue
    import risc_pkg::*;
#(
    parameter bit          R0_HARDWIRED = 1'b1,
    parameter int unsigned STALL_CNT_W  = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   if_valid,
    input  logic [XLEN-1:0]        if_instr,
    output logic                   if_ready,
    output logic                   ex_valid,
    input  logic                   ex_ready,
    output logic [EX_OP_W-1:0]     ex_op,
    output logic [REG_AW-1:0]      ex_rs,
    output logic [REG_AW-1:0]      ex_rt,
    output logic [REG_AW-1:0]      ex_dst,
    output logic                   ex_we,
    output logic [XLEN-1:0]        ex_imm,
    output logic [FUNCT_W-1:0]     ex_funct,
    input  logic                   wb_valid,
    input  logic [REG_AW-1:0]      wb_dst,
    output logic [STALL_CNT_W-1:0] stall_cnt
);

    logic [OPC_W-1:0]   w_opcode;
    logic [REG_AW-1:0]  w_rs, w_rt, w_rd, w_dst;
    ex_op_e             w_op;
    logic               w_use_rs, w_use_rt, w_we;
    logic [NREGS-1:0]   w_busy, w_clr_mask, w_r0_mask, w_busy_eff;
    logic               w_hazard, w_transfer, w_blocked, w_set_en;
    issue_state_e       r_state, w_state_next;
    logic               r_ex_valid, w_ex_valid_next;

    logic [EX_OP_W-1:0]     r_ex_op;
    logic [REG_AW-1:0]      r_ex_rs, r_ex_rt, r_ex_dst;
    logic                   r_ex_we;
    logic [XLEN-1:0]        r_ex_imm;
    logic [FUNCT_W-1:0]     r_ex_funct;
    logic [STALL_CNT_W-1:0] r_stall_cnt;

    assign w_opcode = if_instr[OPC_HI:OPC_LO];
    assign w_rs     = if_instr[RS_HI:RS_LO];
    assign w_rt     = if_instr[RT_HI:RT_LO];
    assign w_rd     = if_instr[RD_HI:RD_LO];

    // Decode opcode into class, source usage and destination.
    always_comb begin
        w_op     = OP_ILLEGAL;
        w_use_rs = 1'b0;
        w_use_rt = 1'b0;
        w_we     = 1'b0;
        w_dst    = '0;
        case (w_opcode)
            OPC_RTYPE: begin w_op = OP_RTYPE; w_use_rs = 1'b1; w_use_rt = 1'b1; w_we = 1'b1; w_dst = w_rd; end
            OPC_ADDI:  begin w_op = OP_ADDI;  w_use_rs = 1'b1; w_we = 1'b1; w_dst = w_rt; end
            OPC_LW:    begin w_op = OP_LW;    w_use_rs = 1'b1; w_we = 1'b1; w_dst = w_rt; end
            OPC_SW:    begin w_op = OP_SW;    w_use_rs = 1'b1; w_use_rt = 1'b1; end
            OPC_BEQ:   begin w_op = OP_BEQ;   w_use_rs = 1'b1; w_use_rt = 1'b1; end
            default:   ;
        endcase
    end

    // A register retiring this cycle is treated as free (writeback bypass); r0 can be excluded.
    assign w_clr_mask = wb_valid ? (NREGS'(1) << wb_dst) : '0;
    assign w_r0_mask  = R0_HARDWIRED ? NREGS'(1) : '0;
    assign w_busy_eff = w_busy & ~w_clr_mask & ~w_r0_mask;

    assign w_hazard   = if_valid && ((w_use_rs && w_busy_eff[w_rs]) ||
                                     (w_use_rt && w_busy_eff[w_rt]) ||
                                     (w_we     && w_busy_eff[w_dst]));
    assign if_ready   = (!r_ex_valid || ex_ready) && !w_hazard;
    assign w_transfer = if_valid && if_ready;
    assign w_blocked  = if_valid && !if_ready;
    assign w_set_en   = w_transfer && w_we && ((w_dst != '0) || !R0_HARDWIRED);

    issue_scoreboard u_sb (
        .clk        (clk),
        .reset      (reset),
        .i_set_en   (w_set_en),
        .i_set_addr (w_dst),
        .i_clr_en   (wb_valid),
        .i_clr_addr (wb_dst),
        .o_busy     (w_busy)
    );

    // Next-state and output-slot occupancy.
    always_comb begin
        w_state_next    = r_state;
        w_ex_valid_next = r_ex_valid;
        if (w_transfer) begin
            w_state_next    = ST_ISSUED;
            w_ex_valid_next = 1'b1;
        end else if (w_blocked) begin
            w_state_next = ST_STALL;
            if (r_ex_valid && ex_ready) w_ex_valid_next = 1'b0;
        end else if (r_ex_valid && ex_ready) begin
            w_state_next    = ST_IDLE;
            w_ex_valid_next = 1'b0;
        end else if (r_state == ST_STALL) begin
            w_state_next = r_ex_valid ? ST_ISSUED : ST_IDLE;
        end
    end

    // State register, issued-instruction slot and saturating stall counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_ex_valid  <= 1'b0;
            r_ex_op     <= '0;
            r_ex_rs     <= '0;
            r_ex_rt     <= '0;
            r_ex_dst    <= '0;
            r_ex_we     <= 1'b0;
            r_ex_imm    <= '0;
            r_ex_funct  <= '0;
            r_stall_cnt <= '0;
        end else begin
            r_state    <= w_state_next;
            r_ex_valid <= w_ex_valid_next;
            if (w_transfer) begin
                r_ex_op    <= w_op;
                r_ex_rs    <= w_rs;
                r_ex_rt    <= w_rt;
                r_ex_dst   <= w_dst;
                r_ex_we    <= w_we;
                r_ex_imm   <= sext_imm(if_instr[IMM_HI:IMM_LO]);
                r_ex_funct <= if_instr[FUNCT_HI:FUNCT_LO];
            end
            if (w_blocked && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + STALL_CNT_W'(1);
        end
    end

    assign ex_valid  = r_ex_valid;
    assign ex_op     = r_ex_op;
    assign ex_rs     = r_ex_rs;
    assign ex_rt     = r_ex_rt;
    assign ex_dst    = r_ex_dst;
    assign ex_we     = r_ex_we;
    assign ex_imm    = r_ex_imm;
    assign ex_funct  = r_ex_funct;
    assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_instr_issue.sv
// Scoreboard bench for instr_issue: directed instructions, expected ex_* queued, monitor compares on consume.
module tb_instr_issue;
    import risc_pkg::*;

    typedef struct packed {
        logic [2:0]  op;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  dst;
        logic        we;
        logic [31:0] imm;
        logic [5:0]  funct;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_valid;
    logic [31:0] if_instr;
    logic        if_ready;
    logic        ex_valid;
    logic        ex_ready;
    logic [2:0]  ex_op;
    logic [4:0]  ex_rs, ex_rt, ex_dst;
    logic        ex_we;
    logic [31:0] ex_imm;
    logic [5:0]  ex_funct;
    logic        wb_valid;
    logic [4:0]  wb_dst;
    logic [15:0] stall_cnt;

    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t q[$];

    instr_issue #(.R0_HARDWIRED(1'b1), .STALL_CNT_W(16)) dut (
        .clk(clk), .reset(reset),
        .if_valid(if_valid), .if_instr(if_instr), .if_ready(if_ready),
        .ex_valid(ex_valid), .ex_ready(ex_ready),
        .ex_op(ex_op), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_dst(ex_dst),
        .ex_we(ex_we), .ex_imm(ex_imm), .ex_funct(ex_funct),
        .wb_valid(wb_valid), .wb_dst(wb_dst), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, got, exp);
        end
    endtask

    function automatic exp_t mk(input logic [2:0] op, input logic [4:0] rs, input logic [4:0] rt,
                                input logic [4:0] dst, input logic we, input logic [31:0] imm,
                                input logic [5:0] funct);
        exp_t e;
        e.op = op; e.rs = rs; e.rt = rt; e.dst = dst; e.we = we; e.imm = imm; e.funct = funct;
        return e;
    endfunction

    // Monitor: compare each consumed instruction against the oldest expectation.
    always @(negedge clk) begin
        if (reset && ex_valid && ex_ready) begin
            exp_t g;
            g = mk(ex_op, ex_rs, ex_rt, ex_dst, ex_we, ex_imm, ex_funct);
            n_tests++;
            if (q.size() == 0) begin
                n_fail++;
                $display("FAIL ex_unexpected: got %h, required no output", g);
            end else begin
                exp_t e;
                e = q.pop_front();
                if (g !== e) begin
                    n_fail++;
                    $display("FAIL ex_payload: got %h, required %h", g, e);
                end
            end
        end
    end

    // Present one instruction from posedge+1; returns the number of blocked cycles before transfer.
    task automatic issue(input logic [31:0] instr, input exp_t e, input int max_wait, output int waited);
        if_valid = 1'b1;
        if_instr = instr;
        waited   = 0;
        @(negedge clk);
        while (!if_ready && waited < max_wait) begin
            @(posedge clk); #1;
            waited++;
            @(negedge clk);
        end
        if (if_ready) begin
            q.push_back(e);
            @(posedge clk); #1;
        end else begin
            n_tests++;
            n_fail++;
            $display("FAIL issue_timeout: got if_ready=0 after %0d cycles, required transfer", waited);
            @(posedge clk); #1;
        end
        if_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    initial begin
        int w;
        reset = 1'b0; if_valid = 1'b0; if_instr = '0; ex_ready = 1'b1; wb_valid = 1'b0; wb_dst = '0;

        // Reset state
        @(negedge clk);
        check("rst_ex_valid", 64'(ex_valid), 64'd0);
        check("rst_ex_fields", {ex_op, ex_dst, ex_imm, ex_we}, 64'd0);
        check("rst_stall_cnt", 64'(stall_cnt), 64'd0);
        @(posedge clk); #1;
        reset = 1'b1;

        // Back-to-back independent ADDIs
        issue(32'h20010005, mk(OP_ADDI, 5'd0, 5'd1, 5'd1, 1'b1, 32'd5, 6'd5), 8, w);
        check("b2b_first_wait", 64'(w), 64'd0);
        issue(32'h20020007, mk(OP_ADDI, 5'd0, 5'd2, 5'd2, 1'b1, 32'd7, 6'd7), 8, w);
        check("b2b_second_wait", 64'(w), 64'd0);
        @(negedge clk);
        check("b2b_stall_cnt", 64'(stall_cnt), 64'd0);
        @(posedge clk); #1;

        // RAW on r3, released by writeback bypass in the fourth cycle
        issue(32'h20030009, mk(OP_ADDI, 5'd0, 5'd3, 5'd3, 1'b1, 32'd9, 6'd9), 8, w);
        if_valid = 1'b1; if_instr = 32'h00602020;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("raw_blocked", 64'(if_ready), 64'd0);
            @(posedge clk); #1;
        end
        wb_valid = 1'b1; wb_dst = 5'd3;
        @(negedge clk);
        check("raw_bypass_ready", 64'(if_ready), 64'd1);
        q.push_back(mk(OP_RTYPE, 5'd3, 5'd0, 5'd4, 1'b1, 32'h00002020, 6'h20));
        @(posedge clk); #1;
        if_valid = 1'b0; wb_valid = 1'b0;
        @(negedge clk);
        check("raw_stall_cnt", 64'(stall_cnt), 64'd3);
        @(posedge clk); #1;

        // Backpressure: held ADDI r6 must stay stable for 4 cycles
        ex_ready = 1'b0;
        issue(32'h2006FFFF, mk(OP_ADDI, 5'd0, 5'd6, 5'd6, 1'b1, 32'hFFFFFFFF, 6'h3F), 8, w);
        check("bp_first_wait", 64'(w), 64'd0);
        if_valid = 1'b1; if_instr = 32'hAC000008;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("bp_if_ready", 64'(if_ready), 64'd0);
            check("bp_hold", {ex_valid, ex_dst, ex_imm}, {1'b1, 5'd6, 32'hFFFFFFFF});
            @(posedge clk); #1;
        end
        ex_ready = 1'b1;
        @(negedge clk);
        check("bp_release_ready", 64'(if_ready), 64'd1);
        q.push_back(mk(OP_SW, 5'd0, 5'd0, 5'd0, 1'b0, 32'd8, 6'd8));
        @(posedge clk); #1;
        if_valid = 1'b0;
        @(negedge clk);
        check("bp_stall_cnt", 64'(stall_cnt), 64'd7);
        @(posedge clk); #1;

        // Same-edge set and clear of r5: set must win
        wb_valid = 1'b1; wb_dst = 5'd5;
        issue(32'h20050001, mk(OP_ADDI, 5'd0, 5'd5, 5'd5, 1'b1, 32'd1, 6'd1), 8, w);
        wb_valid = 1'b0;
        if_valid = 1'b1; if_instr = 32'h20A80002;
        @(negedge clk);
        check("setclr_r5_busy", 64'(if_ready), 64'd0);
        @(posedge clk); #1;
        wb_valid = 1'b1; wb_dst = 5'd5;
        @(negedge clk);
        check("setclr_release", 64'(if_ready), 64'd1);
        q.push_back(mk(OP_ADDI, 5'd5, 5'd8, 5'd8, 1'b1, 32'd2, 6'd2));
        @(posedge clk); #1;
        if_valid = 1'b0; wb_valid = 1'b0;

        // r0 never busy; illegal opcode issues without reading or writing
        issue(32'h20000003, mk(OP_ADDI, 5'd0, 5'd0, 5'd0, 1'b1, 32'd3, 6'd3), 8, w);
        issue(32'h00004821, mk(OP_RTYPE, 5'd0, 5'd0, 5'd9, 1'b1, 32'h00004821, 6'h21), 8, w);
        check("r0_no_stall", 64'(w), 64'd0);
        issue(32'hFC221234, mk(OP_ILLEGAL, 5'd1, 5'd2, 5'd0, 1'b0, 32'h00001234, 6'h34), 8, w);
        check("illegal_no_stall", 64'(w), 64'd0);
        @(negedge clk);
        check("r0_stall_cnt", 64'(stall_cnt), 64'd8);
        @(posedge clk); #1;

        // Asynchronous reset during a stall with r3 busy and an instruction held
        idle(1);
        ex_ready = 1'b0;
        issue(32'h20030004, mk(OP_ADDI, 5'd0, 5'd3, 5'd3, 1'b1, 32'd4, 6'd4), 8, w);
        if_valid = 1'b1; if_instr = 32'h00605020;
        @(negedge clk);
        check("rst_pre_blocked", 64'(if_ready), 64'd0);
        @(posedge clk); #3;
        reset = 1'b0;
        #1;
        check("rst_async_ex_valid", 64'(ex_valid), 64'd0);
        check("rst_async_stall_cnt", 64'(stall_cnt), 64'd0);
        check("rst_async_fields", {ex_op, ex_dst, ex_imm, ex_we}, 64'd0);
        q.delete();
        if_valid = 1'b0; ex_ready = 1'b1;
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        issue(32'h00605020, mk(OP_RTYPE, 5'd3, 5'd0, 5'd10, 1'b1, 32'h00005020, 6'h20), 8, w);
        check("rst_busy_cleared", 64'(w), 64'd0);
        @(negedge clk);
        check("rst_post_stall_cnt", 64'(stall_cnt), 64'd0);

        idle(3);
        check("queue_drained", 64'(q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
